i_decode: RTL and testbench
===========================

Name: i_decode

Overview:
- MIPS ID stage; the consumer end of the IF/ID latch driven by the fetch stage.
- Decodes the instruction word and reads a 32x32 register file that the WB stage writes.
- Sign-extends the immediate and loads the ID/EX pipeline register.
- Detects load-use hazards: drives `stall` back to the fetch stage and squashes on a taken-branch flush.

Parameters:
- DATA_W, 32: datapath width; only 32 is supported, used for port sizing.
- RF_INIT, 32'h0000_0000: reset value of registers r1..r31. r0 always reads 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_id_ir  in  32  instruction from the IF/ID latch
- if_id_npc  in  32  PC+4 from the IF/ID latch
- flush  in  1  taken branch resolved in MEM (PCSrc); squash the instruction in ID
- wb_reg_write  in  1  WB register write enable
- wb_write_reg  in  5  WB destination register
- wb_write_data  in  32  WB write data
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- id_ex_npc  out  32  registered NPC
- id_ex_rdata1  out  32  registered rs value
- id_ex_rdata2  out  32  registered rt value
- id_ex_imm  out  32  registered sign-extended imm[15:0]
- id_ex_rt  out  5  registered instr[20:16]
- id_ex_rd  out  5  registered instr[15:11]
- id_ex_wb  out  2  {RegWrite, MemtoReg}
- id_ex_m  out  3  {Branch, MemRead, MemWrite}
- id_ex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}

Behaviour:
- Reset (rst_n=0, async): all id_ex_* outputs are 0; r1..r31 are set to RF_INIT. stall=0 while in reset. Deassertion is sampled on the next clk edge.
- Latency: an instruction on if_id_ir at edge N appears on id_ex_* after edge N.
- Decode on opcode instr[31:26], giving {RegDst,ALUOp,ALUSrc | Branch,MemRead,MemWrite | RegWrite,MemtoReg}:
  - 6'h00 R-type: 1,10,0 | 0,0,0 | 1,0
  - 6'h23 lw: 0,00,1 | 0,1,0 | 1,1
  - 6'h2B sw: 0,00,1 | 0,0,1 | 0,0
  - 6'h04 beq: 0,01,0 | 1,0,0 | 0,0
  - any other opcode: all control bits 0 (NOP).
- Register file:
  - Reads rs=instr[25:21] and rt=instr[20:16] combinationally.
  - Write at rising clk when wb_reg_write=1 and wb_write_reg!=0. Writes to r0 are ignored; r0 reads 0.
- Immediate: {{16{instr[15]}}, instr[15:0]}.
- Hazard:
  - stall = id_ex_m[1] & (id_ex_rt!=0) & (id_ex_rt==rs | id_ex_rt==rt) & ~flush.
  - While stalled, ID/EX captures the data fields normally but all control fields (wb/m/ex) are 0 (bubble).
  - The instruction is re-presented next cycle because the fetch stage honours stall.
- Flush=1: ID/EX control fields are loaded as 0 and stall is forced to 0 (flush wins over stall). The register-file write still occurs.
- Stall never lasts more than 1 consecutive cycle for the same lw: the bubble clears id_ex_m[1].
- rst_n asserted mid-stall: outputs return to reset values immediately, and stall drops to 0.

Optional Feature:
- RF_BYPASS_EN: when defined, a read of register X in the same cycle as a WB write to X (X!=0) returns wb_write_data (write-first).
- When undefined, the read returns the old contents; the WB-to-ID distance then requires software spacing.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> every id_ex_* output is 0 and stall=0. Read r5 after release -> RF_INIT.
- Write then R-type: WB writes r1=0x11, r2=0x22; present add r3,r1,r2 (0x00221820) with npc 0x104 -> after 1 edge:
  - rdata1=0x11, rdata2=0x22, rd=3, ex=4'b1100, wb=2'b10, npc=0x104.
- lw decode: lw r4,-4(r1) (0x8C24FFFC) -> imm=0xFFFFFFFC, ex=4'b0001, m=3'b010, wb=2'b11, rt=4.
- Load-use: lw r4 then add r5,r4,r1:
  - stall=1 for exactly 1 cycle, and the bubble has wb/m/ex=0.
  - The add then issues normally. The same sequence with lw to r0 gives no stall.
- Flush: assert flush with a stall condition present -> stall=0, and the next id_ex control fields are 0.
- r0 and bypass: a WB write of 0xDEAD to r0 still reads 0. A same-cycle WB write of r6=0x55 while reading r6:
  - with RF_BYPASS_EN -> rdata1=0x55;
  - without it -> the old value.

Source files
------------

// File: rtl/i_decode.sv
// MIPS ID stage: decode, 32x32 regfile, ID/EX register; optional write-first bypass under RF_BYPASS_EN.
// One cycle to id_ex_*; combinational stall on load-use (bubble inserted), flush squashes and overrides stall.
module i_decode #(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] RF_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_id_ir,
  input  logic [DATA_W-1:0] if_id_npc,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              stall,
  output logic [DATA_W-1:0] id_ex_npc,
  output logic [DATA_W-1:0] id_ex_rdata1,
  output logic [DATA_W-1:0] id_ex_rdata2,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [1:0]        id_ex_wb,
  output logic [2:0]        id_ex_m,
  output logic [3:0]        id_ex_ex
);

  logic [DATA_W-1:0] rf [32];
  logic [4:0]        rs, rt;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic [8:0]        ctrl;
  logic              wb_wr_en;

  assign rs       = if_id_ir[25:21];
  assign rt       = if_id_ir[20:16];
  assign wb_wr_en = wb_reg_write && (wb_write_reg != 5'd0);

  // rf[0] is never written, so it stays at reset zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf[0] <= '0;
      for (int i = 1; i < 32; i++) rf[i] <= RF_INIT;
    end else if (wb_wr_en) begin
      rf[wb_write_reg] <= wb_write_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs != 5'd0) rdata1 = rf[rs];
    if (rt != 5'd0) rdata2 = rf[rt];
`ifdef RF_BYPASS_EN
    if (wb_wr_en && wb_write_reg == rs) rdata1 = wb_write_data;
    if (wb_wr_en && wb_write_reg == rt) rdata2 = wb_write_data;
`else
`endif
  end

  // ctrl = {RegWrite,MemtoReg | Branch,MemRead,MemWrite | RegDst,ALUOp,ALUSrc}
  always_comb begin
    ctrl = '0;
    case (if_id_ir[31:26])
      6'h00:   ctrl = {2'b10, 3'b000, 4'b1100};
      6'h23:   ctrl = {2'b11, 3'b010, 4'b0001};
      6'h2B:   ctrl = {2'b00, 3'b001, 4'b0001};
      6'h04:   ctrl = {2'b00, 3'b100, 4'b0010};
      default: ctrl = '0;
    endcase
  end

  assign stall = rst_n & id_ex_m[1] & (id_ex_rt != 5'd0) &
                 ((id_ex_rt == rs) | (id_ex_rt == rt)) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_npc    <= '0;
      id_ex_rdata1 <= '0;
      id_ex_rdata2 <= '0;
      id_ex_imm    <= '0;
      id_ex_rt     <= '0;
      id_ex_rd     <= '0;
      id_ex_wb     <= '0;
      id_ex_m      <= '0;
      id_ex_ex     <= '0;
    end else begin
      id_ex_npc    <= if_id_npc;
      id_ex_rdata1 <= rdata1;
      id_ex_rdata2 <= rdata2;
      id_ex_imm    <= {{(DATA_W-16){if_id_ir[15]}}, if_id_ir[15:0]};
      id_ex_rt     <= rt;
      id_ex_rd     <= if_id_ir[15:11];
      if (stall || flush) begin
        id_ex_wb <= '0;
        id_ex_m  <= '0;
        id_ex_ex <= '0;
      end else begin
        {id_ex_wb, id_ex_m, id_ex_ex} <= ctrl;
      end
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: expected ID/EX contents queued at drive time, compared after the edge.
module tb_i_decode;

  localparam logic [31:0] RFI = 32'h1234_5678;

  typedef struct packed {
    logic [31:0] npc, r1, r2, imm;
    logic [4:0]  rt, rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_id_ir = '0, if_id_npc = '0, wb_write_data = '0;
  logic        flush = 1'b0, wb_reg_write = 1'b0;
  logic [4:0]  wb_write_reg = '0;
  logic        stall;
  logic [31:0] id_ex_npc, id_ex_rdata1, id_ex_rdata2, id_ex_imm;
  logic [4:0]  id_ex_rt, id_ex_rd;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t last;
  logic [31:0] mrf [32];

  i_decode #(.DATA_W(32), .RF_INIT(RFI)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .if_id_npc(if_id_npc),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .stall(stall), .id_ex_npc(id_ex_npc),
    .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2), .id_ex_imm(id_ex_imm),
    .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_wb(id_ex_wb),
    .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {wb,m,ex} straight from the opcode table
  function automatic logic [8:0] dec(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wr, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we && wr == a) return wd;
`else
`endif
    return mrf[a];
  endfunction

  task automatic model_reset();
    mrf[0] = '0;
    for (int i = 1; i < 32; i++) mrf[i] = RFI;
    last = '0;
  endtask

  task automatic step(input logic [31:0] ir, input logic [31:0] npc, input logic fl,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    exp_t e, got;
    logic es;
    @(negedge clk);
    if_id_ir = ir; if_id_npc = npc; flush = fl;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    #1;
    es = last.m[1] && last.rt != 5'd0 &&
         (last.rt == ir[25:21] || last.rt == ir[20:16]) && !fl;
    check("stall", {31'b0, stall}, {31'b0, es});
    e.npc = npc;
    e.r1  = mread(ir[25:21], we, wr, wd);
    e.r2  = mread(ir[20:16], we, wr, wd);
    e.imm = {{16{ir[15]}}, ir[15:0]};
    e.rt  = ir[20:16];
    e.rd  = ir[15:11];
    {e.wb, e.m, e.ex} = (es || fl) ? 9'b0 : dec(ir[31:26]);
    sb.push_back(e);
    @(posedge clk);
    if (we && wr != 5'd0) mrf[wr] = wd;
    last = e;
    #1;
    got = sb.pop_front();
    check("npc", id_ex_npc, got.npc);
    check("rdata1", id_ex_rdata1, got.r1);
    check("rdata2", id_ex_rdata2, got.r2);
    check("imm", id_ex_imm, got.imm);
    check("rt_rd", {22'b0, id_ex_rt, id_ex_rd}, {22'b0, got.rt, got.rd});
    check("ctrl", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, {23'b0, got.wb, got.m, got.ex});
  endtask

  localparam logic [31:0] NOP     = 32'hFC00_0000;
  localparam logic [31:0] ADD3    = 32'h0022_1820;  // add r3,r1,r2
  localparam logic [31:0] LW4     = 32'h8C24_FFFC;  // lw r4,-4(r1)
  localparam logic [31:0] ADD_DEP = 32'h0081_2820;  // add r5,r4,r1
  localparam logic [31:0] LW0     = 32'h8C20_0000;  // lw r0,0(r1)
  localparam logic [31:0] ADD_R0  = 32'h0001_2820;  // add r5,r0,r1

  initial begin
    logic [5:0]  ops [5];
    logic [31:0] ir;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_id_ir = $urandom; if_id_npc = $urandom; flush = 1'($urandom);
      wb_reg_write = 1'b1; wb_write_reg = 5'($urandom); wb_write_data = $urandom;
      @(posedge clk); #1;
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_data", id_ex_npc | id_ex_rdata1 | id_ex_rdata2 | id_ex_imm, 32'h0);
      check("rst_ctrl", {13'b0, id_ex_rt, id_ex_rd, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1; wb_reg_write = 1'b0; if_id_ir = NOP; flush = 1'b0;

    step({6'h3F, 5'd5, 5'd0, 16'h0}, 32'h100, 0, 0, 0, 0);
    check("r5_init", id_ex_rdata1, RFI);

    step(NOP, 32'h0, 0, 1, 5'd1, 32'h11);
    step(NOP, 32'h0, 0, 1, 5'd2, 32'h22);
    step(ADD3, 32'h104, 0, 0, 0, 0);
    check("add_r1", id_ex_rdata1, 32'h11);
    check("add_r2", id_ex_rdata2, 32'h22);
    check("add_rd", {27'b0, id_ex_rd}, 32'd3);
    check("add_ex", {28'b0, id_ex_ex}, 32'hC);
    check("add_wb", {30'b0, id_ex_wb}, 32'h2);

    step(LW4, 32'h108, 0, 0, 0, 0);
    check("lw_imm", id_ex_imm, 32'hFFFF_FFFC);
    check("lw_ctrl", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, {23'b0, 2'b11, 3'b010, 4'b0001});
    check("lw_rt", {27'b0, id_ex_rt}, 32'd4);
    step(ADD_DEP, 32'h10C, 0, 0, 0, 0);
    check("bubble", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);
    step(ADD_DEP, 32'h10C, 0, 0, 0, 0);
    check("add_after", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, {23'b0, 2'b10, 3'b000, 4'b1100});

    step(LW0, 32'h110, 0, 0, 0, 0);
    step(ADD_R0, 32'h114, 0, 0, 0, 0);

    step(LW4, 32'h118, 0, 0, 0, 0);
    step(ADD_DEP, 32'h11C, 1, 0, 0, 0);
    check("flush_ctrl", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);

    step(NOP, 32'h0, 0, 1, 5'd0, 32'hDEAD);
    step(32'h0000_0020, 32'h120, 0, 0, 0, 0);
    check("r0_zero", id_ex_rdata1 | id_ex_rdata2, 32'h0);

    step({6'h00, 5'd6, 5'd0, 16'h3020}, 32'h124, 0, 1, 5'd6, 32'h55);
`ifdef RF_BYPASS_EN
    check("r6_same", id_ex_rdata1, 32'h55);
`else
    check("r6_same", id_ex_rdata1, RFI);
`endif
    step({6'h00, 5'd6, 5'd0, 16'h3020}, 32'h128, 0, 0, 0, 0);
    check("r6_next", id_ex_rdata1, 32'h55);

    for (int i = 0; i < 60; i++) begin
      ir = $urandom;
      ir[31:26] = ops[$urandom_range(0, 4)];
      step(ir, $urandom, ($urandom_range(0, 7) == 0), 1'($urandom),
           5'($urandom), $urandom);
    end

    // Reset arriving while a load-use stall is active
    step(LW4, 32'h200, 0, 0, 0, 0);
    @(negedge clk);
    if_id_ir = ADD_DEP; flush = 1'b0; wb_reg_write = 1'b0;
    #1;
    check("pre_rst_stall", {31'b0, stall}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'b0, stall}, 32'h0);
    check("mid_rst_out", id_ex_npc | {29'b0, id_ex_m}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step({6'h3F, 5'd1, 5'd6, 16'h0}, 32'h300, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
